// File: rtl/sar_search_4bit.sv
// Successive-approximation search controller: drives a trial operand into an external comparator
// and rebuilds the unknown operand MSB first. Define SAR_EARLY_EXIT_EN to stop as soon as eq is seen.
module sar_search_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_sm,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned IdxW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  trial_q, trial_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  decided;
  logic              flags_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= IdxW'(WIDTH - 1);
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    flags_ok = ({cmp_eq, cmp_gt, cmp_sm} == 3'b100) ||
               ({cmp_eq, cmp_gt, cmp_sm} == 3'b010) ||
               ({cmp_eq, cmp_gt, cmp_sm} == 3'b001);
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    err_d    = err_q;
    decided  = trial_q;

    unique case (state_q)
      StIdle: begin
        trial_d = '0;
        if (start) begin
          trial_d = {1'b1, {(WIDTH - 1){1'b0}}};
          idx_d   = IdxW'(WIDTH - 1);
          err_d   = 1'b0;
          state_d = StSearch;
        end
      end
      StSearch: begin
        if (!flags_ok) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          trial_d  = '0;
          state_d  = StIdle;
        end else begin
          // eq and gt both mean the trial bit is not above a, so it stays set
          if (cmp_sm) begin
            decided[idx_q] = 1'b0;
          end
`ifdef SAR_EARLY_EXIT_EN
          if (cmp_eq) begin
            result_d = trial_q;
            done_d   = 1'b1;
            trial_d  = '0;
            state_d  = StIdle;
          end else
`endif
          if (idx_q == '0) begin
            result_d = decided;
            done_d   = 1'b1;
            trial_d  = '0;
            state_d  = StIdle;
          end else begin
            decided[idx_q - 1'b1] = 1'b1;
            trial_d = decided;
            idx_d   = idx_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        trial_d = '0;
      end
    endcase
  end

  assign trial  = trial_q;
  assign busy   = (state_q == StSearch);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Directed bench for sar_search_4bit: a behavioural comparator around an unknown value a_val,
// a table of hand-computed searches, and hand-written error, held-start and reset sequences.
module tb_sar_search_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cmp_eq, cmp_gt, cmp_sm;
  logic [3:0] trial;
  logic       busy, done, err;
  logic [3:0] result;

  logic [3:0] a_val;
  logic       inject;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] seq;   // expected trials, first trial in the top nibble
    int          lat;   // compare edges from start to done
    logic [3:0]  res;
  } vec_t;

  vec_t vecs[8];

  sar_search_4bit #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_sm (cmp_sm),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Combinational comparator; inject forces an illegal gt+sm pattern.
  always_comb begin
    cmp_eq = inject ? 1'b0 : (a_val == trial);
    cmp_gt = inject ? 1'b1 : (a_val > trial);
    cmp_sm = inject ? 1'b1 : (a_val < trial);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_search(input vec_t v);
    int n;
    logic [3:0] exp_t;
    a_val = v.a;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      if (n < v.lat) begin
        exp_t = 4'((v.seq >> (12 - 4 * n)) & 16'hF);
        chk($sformatf("trial a=%0d step%0d", v.a, n), int'(trial), int'(exp_t));
      end
      n++;
      @(negedge clk);
    end
    chk($sformatf("latency a=%0d", v.a), n, v.lat);
    chk($sformatf("done a=%0d", v.a), int'(done), 1);
    chk($sformatf("result a=%0d", v.a), int'(result), int'(v.res));
    chk($sformatf("err a=%0d", v.a), int'(err), 0);
    chk($sformatf("trial_idle a=%0d", v.a), int'(trial), 0);
    @(negedge clk);
    chk($sformatf("done_pulse a=%0d", v.a), int'(done), 0);
    chk($sformatf("result_held a=%0d", v.a), int'(result), int'(v.res));
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 12) begin
      n++;
      @(negedge clk);
    end
    chk(name, int'(done), 1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{a: 4'd11, seq: 16'h8CAB, lat: 4, res: 4'd11};
`ifdef SAR_EARLY_EXIT_EN
    vecs[1] = '{a: 4'd8,  seq: 16'h8000, lat: 1, res: 4'd8};
    vecs[5] = '{a: 4'd6,  seq: 16'h8460, lat: 3, res: 4'd6};
`else
    vecs[1] = '{a: 4'd8,  seq: 16'h8CA9, lat: 4, res: 4'd8};
    vecs[5] = '{a: 4'd6,  seq: 16'h8467, lat: 4, res: 4'd6};
`endif
    vecs[2] = '{a: 4'd0,  seq: 16'h8421, lat: 4, res: 4'd0};
    vecs[3] = '{a: 4'd15, seq: 16'h8CEF, lat: 4, res: 4'd15};
    vecs[4] = '{a: 4'd5,  seq: 16'h8465, lat: 4, res: 4'd5};
    vecs[6] = '{a: 4'd13, seq: 16'h8CED, lat: 4, res: 4'd13};
    vecs[7] = '{a: 4'd1,  seq: 16'h8421, lat: 4, res: 4'd1};

    rst = 1'b1;
    start = 1'b0;
    inject = 1'b0;
    a_val = 4'd0;
    #1;
    chk("reset trial", int'(trial), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset result", int'(result), 0);
    chk("reset err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_search(vecs[i]);
    end

    // Illegal gt+sm on the second compare edge aborts with err.
    a_val = 4'd5;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    chk("abort done", int'(done), 1);
    chk("abort err", int'(err), 1);
    chk("abort result", int'(result), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort trial", int'(trial), 0);
    @(negedge clk);
    chk("abort err_held", int'(err), 1);
    chk("abort done_pulse", int'(done), 0);
    v = '{a: 4'd5, seq: 16'h8465, lat: 4, res: 4'd5};
    run_search(v);

    // start held high across a whole search: ignored until the done-pulse cycle.
    a_val = 4'd6;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("held first trial", int'(trial), 8);
    @(negedge clk);
    chk("held ignored trial", int'(trial), 4);
    wait_done("held done");
    chk("held result", int'(result), 6);
    chk("held busy_at_done", int'(busy), 0);
    @(negedge clk);
    chk("held restart busy", int'(busy), 1);
    chk("held restart trial", int'(trial), 8);
    chk("held result_kept", int'(result), 6);
    chk("held restart done", int'(done), 0);
    start = 1'b0;
    wait_done("held second done");
    chk("held second result", int'(result), 6);

    // Asynchronous reset after two compare edges.
    @(negedge clk);
    a_val = 4'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset trial", int'(trial), 14);
    #2;
    rst = 1'b1;
    #1;
    chk("async trial", int'(trial), 0);
    chk("async busy", int'(busy), 0);
    chk("async done", int'(done), 0);
    chk("async result", int'(result), 0);
    chk("async err", int'(err), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no done after reset %0d", k), int'(done), 0);
    end
    v = '{a: 4'd13, seq: 16'h8CED, lat: 4, res: 4'd13};
    run_search(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_search_4bit.md
Name: sar_search_4bit

Overview:
- Successive-approximation search controller that sits on the operand side of a magnitude comparator.
- It drives the trial operand `b` into an external combinational comparator whose other operand `a` is an unknown value. It consumes the comparator's eq/gt/sm flags and reconstructs `a` bit by bit, MSB first.
- Used for threshold discovery and for sequential self-check of comparator instances.

Parameters:
- WIDTH, 4, operand width in bits (≥2); also the search length in compare cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new search; sampled only in IDLE.
- cmp_eq  input  1  comparator flag: a == trial.
- cmp_gt  input  1  comparator flag: a > trial.
- cmp_sm  input  1  comparator flag: a < trial.
- trial  output  WIDTH  registered operand driven to the comparator `b` input.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when the search ends (normal or error).
- result  output  WIDTH  recovered value; held from the done pulse until the next accepted start.
- err  output  1  set with done when the compare flags were not one-hot; held with result.

Behaviour:
- Reset (async, rst=1): state=IDLE, trial=0, busy=0, done=0, result=0, err=0, bit index=WIDTH-1. Reset mid-search aborts immediately with no done pulse.
- FSM states: IDLE, SEARCH.
- IDLE:
  - done=0 except for the single pulse cycle. busy=0. trial=0.
  - start=1 at an edge: trial <= 1<<(WIDTH-1), idx <= WIDTH-1, err <= 0, state <= SEARCH.
  - result is not cleared at start; it changes only at the end of a search.
- SEARCH:
  - busy=1.
  - The comparator is combinational, so the flags for the current trial are sampled at each edge.
  - Per edge, for bit idx:
    - cmp_sm=1: clear trial[idx].
    - cmp_gt=1 or cmp_eq=1: keep trial[idx]=1.
    - If idx>0: set trial[idx-1]=1, idx <= idx-1.
    - If idx==0: result <= final decided value, done <= 1, busy <= 0, trial <= 0, state <= IDLE.
- Flag check:
  - At any SEARCH edge where {cmp_eq,cmp_gt,cmp_sm} is not exactly one-hot (zero or multiple set): abort.
  - On abort: result <= 0, err <= 1, done <= 1, state <= IDLE, trial <= 0.
- Latency: start sampled at edge E0; compare decisions at E1..E_WIDTH; done high during the cycle following E_WIDTH. For WIDTH=4, done appears 4 edges after the start edge.
- start while busy: ignored, no queueing.
- start on the same edge that done is produced: ignored (state is still SEARCH at that edge). A start asserted during the done-pulse cycle is accepted.
- Arithmetic: result range 0..2^WIDTH-1. With a consistent comparator, result==a exactly. a=0 yields all bits cleared. a=2^WIDTH-1 yields all bits kept.

Optional Feature:
- Macro SAR_EARLY_EXIT_EN.
- Defined: at any SEARCH edge with cmp_eq=1 (one-hot valid), the current trial is exact. result <= trial, done <= 1, state <= IDLE; the remaining bits are skipped. Latency becomes (number of bits examined) edges.
- Not defined: cmp_eq is treated like cmp_gt (keep bit), and every search takes exactly WIDTH compare edges.
- Flag checking and err behaviour are identical in both builds.

Test Plan:
- Model comparator with a=11, start pulse → trials 8,12,10,11; done one cycle after the 4th compare edge; result=11, err=0. Identical result with SAR_EARLY_EXIT_EN, since eq occurs on bit 0.
- a=8:
  - Without macro → trials 8,12,10,9; result=8 after 4 edges.
  - With SAR_EARLY_EXIT_EN → only trial 8 is driven; done after 1 compare edge, result=8.
- a=0 and a=15 → result 0 and 15 respectively, err=0. busy high for exactly 4 cycles (no early exit for a=0; a=15 eq only on the last trial).
- Force cmp_gt=cmp_sm=1 on the 2nd compare edge → done pulse on the next cycle with err=1, result=0. A subsequent clean search with a=5 gives result=5, err=0.
- start held high through an entire search with a=6 → the second start is ignored until the done-pulse cycle. A new search begins on the edge after done; result=6 is held meanwhile.
- Assert rst asynchronously mid-search (after 2 compare edges, a=13) → all outputs 0 immediately, no done pulse. A fresh start then yields result=13.
